// File: rtl/game_sequencer.sv
// game_sequencer: top-level flow controller for the snake game.
// Sequences START -> ARM -> PLAY <-> PAUSE -> OVER, gates snake stepping,
// filters direction commands from the IR remote, selects the LED matrix
// screen and computes score / high score for the 7-segment display.
// Optional feature macro: SNAKE_HISCORE_EN keeps a best-score register;
// without it high_score is tied to zero and no compare logic exists.
module game_sequencer #(
  parameter logic [31:0] CODE_ENTER = 32'h20DF5AA5,
  parameter logic [31:0] CODE_UP    = 32'h20DF6A95,
  parameter logic [31:0] CODE_DOWN  = 32'h20DFEA15,
  parameter logic [31:0] CODE_LEFT  = 32'h20DF1AE5,
  parameter logic [31:0] CODE_RIGHT = 32'h20DF9A65,
  parameter int unsigned ARM_CYCLES = 16,
  parameter int unsigned OVER_HOLD  = 8,
  parameter int unsigned SCORE_MULT = 5
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic [31:0] ir_word,
  input  logic        ir_valid,
  input  logic        game_tick,
  input  logic        game_over,
  input  logic [7:0]  length,
  output logic        game_rst_n,
  output logic        step,
  output logic [1:0]  dir,
  output logic [1:0]  screen_sel,
  output logic [10:0] score,
  output logic [10:0] high_score
);

  // One counter serves both the ARM delay and the OVER hold-off.
  localparam int unsigned CNT_MAX = (ARM_CYCLES > OVER_HOLD) ? ARM_CYCLES : OVER_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(OVER_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_ARM   = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       screen_sel_q, screen_sel_d;
  logic             step_q, step_d;
  logic             game_rst_n_q, game_rst_n_d;
  logic [10:0]      score_q, score_d;

  logic             ev_enter;
  logic             ev_dir;
  logic [1:0]       ev_code;

  // Decode the IR word into ENTER / direction events; unknown codes do nothing.
  always_comb begin
    ev_enter = ir_valid && (ir_word == CODE_ENTER);
    ev_dir   = 1'b0;
    ev_code  = 2'b11;
    if (ir_valid) begin
      if (ir_word == CODE_UP) begin
        ev_dir  = 1'b1;
        ev_code = 2'b00;
      end else if (ir_word == CODE_DOWN) begin
        ev_dir  = 1'b1;
        ev_code = 2'b01;
      end else if (ir_word == CODE_LEFT) begin
        ev_dir  = 1'b1;
        ev_code = 2'b10;
      end else if (ir_word == CODE_RIGHT) begin
        ev_dir  = 1'b1;
        ev_code = 2'b11;
      end else begin
        ev_dir  = 1'b0;
        ev_code = 2'b11;
      end
    end else begin
      ev_dir  = 1'b0;
      ev_code = 2'b11;
    end
  end

  // Next-state, counter, direction and output computation for the game flow.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    step_d  = 1'b0;
    score_d = 11'(length) * 11'(SCORE_MULT);

    case (state_q)
      ST_START: begin
        if (ev_enter) begin
          state_d = ST_ARM;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_START;
        end
      end
      ST_ARM: begin
        // Engine held in reset; direction restarts heading right.
        dir_d  = 2'b11;
        pend_d = 2'b11;
        if (cnt_q >= ARM_LAST) begin
          state_d = ST_PLAY;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PLAY: begin
        if (game_over) begin
          // Collision wins over every other event in the same cycle.
          state_d = ST_OVER;
          cnt_d   = CNT_ZERO;
        end else begin
          // A tick commits the pending direction seen before this cycle.
          if (game_tick) begin
            step_d = 1'b1;
            dir_d  = pend_q;
          end else begin
            dir_d = dir_q;
          end
          // Reject a reversal relative to the committed direction.
          if (ev_dir && (ev_code != (dir_q ^ 2'b01))) begin
            pend_d = ev_code;
          end else begin
            pend_d = pend_q;
          end
          if (ev_enter) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_PLAY;
          end
        end
      end
      ST_PAUSE: begin
        if (ev_enter) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_OVER: begin
        if (ev_enter && (cnt_q == HOLD_MAX)) begin
          state_d = ST_START;
          cnt_d   = CNT_ZERO;
        end else if (game_tick && (cnt_q < HOLD_MAX)) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_START;
        cnt_d   = CNT_ZERO;
        dir_d   = 2'b11;
        pend_d  = 2'b11;
      end
    endcase

    // Outputs follow the state being entered so they register alongside it.
    case (state_d)
      ST_START: screen_sel_d = 2'd0;
      ST_ARM:   screen_sel_d = 2'd1;
      ST_PLAY:  screen_sel_d = 2'd1;
      ST_PAUSE: screen_sel_d = 2'd3;
      ST_OVER:  screen_sel_d = 2'd2;
      default:  screen_sel_d = 2'd0;
    endcase
    game_rst_n_d = (state_d == ST_PLAY) || (state_d == ST_PAUSE) || (state_d == ST_OVER);
  end

  // Game flow state and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_START;
      cnt_q        <= CNT_ZERO;
      dir_q        <= 2'b11;
      pend_q       <= 2'b11;
      screen_sel_q <= 2'd0;
      step_q       <= 1'b0;
      game_rst_n_q <= 1'b0;
      score_q      <= 11'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      screen_sel_q <= screen_sel_d;
      step_q       <= step_d;
      game_rst_n_q <= game_rst_n_d;
      score_q      <= score_d;
    end
  end

  assign game_rst_n = game_rst_n_q;
  assign step       = step_q;
  assign dir        = dir_q;
  assign screen_sel = screen_sel_q;
  assign score      = score_q;

`ifdef SNAKE_HISCORE_EN
  logic [10:0] high_score_q, high_score_d;

  // Latch the better score on the edge that enters OVER.
  always_comb begin
    if ((state_q == ST_PLAY) && game_over && (score_q > high_score_q)) begin
      high_score_d = score_q;
    end else begin
      high_score_d = high_score_q;
    end
  end

  // Best score since reset_n.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      high_score_q <= 11'd0;
    end else begin
      high_score_q <= high_score_d;
    end
  end

  assign high_score = high_score_q;
`else
  assign high_score = 11'd0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios followed by a
// randomized run compared against an event-level reference model.
module tb_game_sequencer;

  localparam logic [31:0] C_ENTER = 32'h20DF5AA5;
  localparam logic [31:0] C_UP    = 32'h20DF6A95;
  localparam logic [31:0] C_DOWN  = 32'h20DFEA15;
  localparam logic [31:0] C_LEFT  = 32'h20DF1AE5;
  localparam logic [31:0] C_RIGHT = 32'h20DF9A65;
  localparam int ARM_N  = 16;
  localparam int HOLD_N = 8;
  localparam int MULT   = 5;
`ifdef SNAKE_HISCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic        CLOCK_50;
  logic        reset_n;
  logic [31:0] ir_word;
  logic        ir_valid;
  logic        game_tick;
  logic        game_over;
  logic [7:0]  length;
  logic        game_rst_n;
  logic        step;
  logic [1:0]  dir;
  logic [1:0]  screen_sel;
  logic [10:0] score;
  logic [10:0] high_score;

  int n_checks = 0;
  int n_fail   = 0;

  game_sequencer dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .ir_word   (ir_word),
    .ir_valid  (ir_valid),
    .game_tick (game_tick),
    .game_over (game_over),
    .length    (length),
    .game_rst_n(game_rst_n),
    .step      (step),
    .dir       (dir),
    .screen_sel(screen_sel),
    .score     (score),
    .high_score(high_score)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic clk1();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_ir(input logic [31:0] w);
    ir_word  = w;
    ir_valid = 1'b1;
    clk1();
    ir_valid = 1'b0;
  endtask

  task automatic send_tick();
    game_tick = 1'b1;
    clk1();
    game_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clk1();
    clk1();
    n_checks++;
    if ({game_rst_n, step, dir, screen_sel} !== 6'b0_0_11_00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected %b", {game_rst_n, step, dir, screen_sel}, 6'b001100);
    end
    n_checks++;
    if ({score, high_score} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_score: got %0d/%0d expected 0/0", score, high_score);
    end
    reset_n = 1'b1;
    clk1();
  endtask

  task automatic test_arm();
    int n;
    send_ir(C_ENTER);
    n_checks++;
    if ({game_rst_n, screen_sel} !== 3'b0_01) begin
      n_fail++;
      $display("FAIL arm_entry: got rst_n=%b sel=%0d expected rst_n=0 sel=1", game_rst_n, screen_sel);
    end
    n = 0;
    while (game_rst_n === 1'b0 && n < 100) begin
      n++;
      clk1();
    end
    n_checks++;
    if (n !== ARM_N) begin
      n_fail++;
      $display("FAIL arm_len: got %0d cycles expected %0d", n, ARM_N);
    end
    n_checks++;
    if ({game_rst_n, screen_sel, dir} !== 5'b1_01_11) begin
      n_fail++;
      $display("FAIL play_entry: got %b expected %b", {game_rst_n, screen_sel, dir}, 5'b10111);
    end
  endtask

  task automatic test_direction();
    send_ir(C_LEFT);
    send_tick();
    n_checks++;
    if ({step, dir} !== 3'b1_11) begin
      n_fail++;
      $display("FAIL left_reject: got step=%b dir=%b expected step=1 dir=11", step, dir);
    end
    clk1();
    n_checks++;
    if (step !== 1'b0) begin
      n_fail++;
      $display("FAIL step_pulse1: got %b expected 0", step);
    end
    send_ir(C_UP);
    n_checks++;
    if (dir !== 2'b11) begin
      n_fail++;
      $display("FAIL up_pending: got %b expected 11", dir);
    end
    send_tick();
    n_checks++;
    if ({step, dir} !== 3'b1_00) begin
      n_fail++;
      $display("FAIL up_commit: got step=%b dir=%b expected step=1 dir=00", step, dir);
    end
    clk1();
    n_checks++;
    if (step !== 1'b0) begin
      n_fail++;
      $display("FAIL step_pulse2: got %b expected 0", step);
    end
  endtask

  task automatic test_last_wins();
    send_ir(C_RIGHT);
    send_tick();
    n_checks++;
    if (dir !== 2'b11) begin
      n_fail++;
      $display("FAIL right_commit: got %b expected 11", dir);
    end
    send_ir(C_UP);
    send_ir(C_DOWN);
    send_tick();
    n_checks++;
    if (dir !== 2'b01) begin
      n_fail++;
      $display("FAIL last_wins: got %b expected 01", dir);
    end
  endtask

  task automatic test_back_to_back();
    ir_word   = C_LEFT;
    ir_valid  = 1'b1;
    game_tick = 1'b1;
    clk1();
    ir_valid  = 1'b0;
    game_tick = 1'b0;
    n_checks++;
    if ({step, dir} !== 3'b1_01) begin
      n_fail++;
      $display("FAIL same_cycle_old: got step=%b dir=%b expected step=1 dir=01", step, dir);
    end
    send_tick();
    n_checks++;
    if (dir !== 2'b10) begin
      n_fail++;
      $display("FAIL same_cycle_new: got %b expected 10", dir);
    end
    send_ir(C_RIGHT);
    send_ir(32'h20DF0000);
    send_tick();
    n_checks++;
    if ({step, dir} !== 3'b1_10) begin
      n_fail++;
      $display("FAIL reverse_unknown: got step=%b dir=%b expected step=1 dir=10", step, dir);
    end
  endtask

  task automatic test_pause();
    send_ir(C_ENTER);
    n_checks++;
    if ({game_rst_n, screen_sel} !== 3'b1_11) begin
      n_fail++;
      $display("FAIL pause_entry: got rst_n=%b sel=%0d expected rst_n=1 sel=3", game_rst_n, screen_sel);
    end
    send_tick();
    n_checks++;
    if (step !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_step: got %b expected 0", step);
    end
    send_ir(C_UP);
    send_tick();
    n_checks++;
    if ({step, dir} !== 3'b0_10) begin
      n_fail++;
      $display("FAIL pause_dir: got step=%b dir=%b expected step=0 dir=10", step, dir);
    end
    send_ir(C_ENTER);
    n_checks++;
    if (screen_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL resume_sel: got %0d expected 1", screen_sel);
    end
    send_tick();
    n_checks++;
    if ({step, dir} !== 3'b1_10) begin
      n_fail++;
      $display("FAIL resume_step: got step=%b dir=%b expected step=1 dir=10", step, dir);
    end
  endtask

  task automatic test_over();
    logic [10:0] exp_hs;
    exp_hs = HS_EN ? 11'd60 : 11'd0;
    length = 8'd12;
    clk1();
    clk1();
    n_checks++;
    if (score !== 11'd60) begin
      n_fail++;
      $display("FAIL score12: got %0d expected 60", score);
    end
    ir_word   = C_ENTER;
    ir_valid  = 1'b1;
    game_over = 1'b1;
    clk1();
    ir_valid = 1'b0;
    n_checks++;
    if ({game_rst_n, step, screen_sel} !== 4'b1_0_10) begin
      n_fail++;
      $display("FAIL over_entry: got %b expected 1010", {game_rst_n, step, screen_sel});
    end
    n_checks++;
    if (high_score !== exp_hs) begin
      n_fail++;
      $display("FAIL hs_first: got %0d expected %0d", high_score, exp_hs);
    end
    for (int i = 0; i < 3; i++) send_tick();
    n_checks++;
    if (step !== 1'b0) begin
      n_fail++;
      $display("FAIL over_step: got %b expected 0", step);
    end
    send_ir(C_ENTER);
    n_checks++;
    if (screen_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL early_enter: got %0d expected 2", screen_sel);
    end
    for (int i = 0; i < 5; i++) send_tick();
    send_ir(C_ENTER);
    n_checks++;
    if ({game_rst_n, screen_sel} !== 3'b0_00) begin
      n_fail++;
      $display("FAIL over_exit: got rst_n=%b sel=%0d expected rst_n=0 sel=0", game_rst_n, screen_sel);
    end
    game_over = 1'b0;
  endtask

  task automatic test_second_game();
    int n;
    logic [10:0] exp_hs;
    exp_hs = HS_EN ? 11'd60 : 11'd0;
    send_ir(C_ENTER);
    n = 0;
    while (game_rst_n !== 1'b1 && n < 100) begin
      n++;
      clk1();
    end
    n_checks++;
    if (game_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL game2_play: got rst_n=%b after %0d cycles expected 1", game_rst_n, n);
    end
    length = 8'd4;
    clk1();
    clk1();
    n_checks++;
    if (score !== 11'd20) begin
      n_fail++;
      $display("FAIL score4: got %0d expected 20", score);
    end
    game_over = 1'b1;
    clk1();
    game_over = 1'b0;
    n_checks++;
    if ({screen_sel, high_score} !== {2'd2, exp_hs}) begin
      n_fail++;
      $display("FAIL hs_keep: got sel=%0d hs=%0d expected sel=2 hs=%0d", screen_sel, high_score, exp_hs);
    end
    for (int i = 0; i < HOLD_N; i++) send_tick();
    send_ir(C_ENTER);
    n_checks++;
    if (screen_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL game2_exit: got %0d expected 0", screen_sel);
    end
  endtask

  // Randomized run: model tracks game phase, pending/committed heading,
  // ARM countdown and OVER hold-off as plain integers.
  task automatic test_random();
    localparam int P_START = 0, P_ARM = 1, P_PLAY = 2, P_PAUSE = 3, P_OVER = 4;
    int phase, arm_left, hold, mdir, mpend, mscore, mhs;
    int nphase, narm, nhold, ndir, npend, nscore, nhs, nstep;
    int sel, code, esel;
    bit v, tk, go, is_enter, is_dir;
    logic [31:0] w;
    logic [27:0] got_v, exp_v;

    reset_n = 1'b0; ir_valid = 1'b0; game_tick = 1'b0; game_over = 1'b0; length = 8'd0;
    clk1();
    reset_n = 1'b1;
    phase = P_START; arm_left = 0; hold = 0; mdir = 3; mpend = 3; mscore = 0; mhs = 0;

    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({game_rst_n, step, dir, screen_sel, score, high_score} !== {6'b0_0_11_00, 22'd0}) begin
          n_fail++;
          $display("FAIL async_reset: got %b", {game_rst_n, step, dir, screen_sel, score, high_score});
        end
        clk1();
        reset_n = 1'b1;
        phase = P_START; arm_left = 0; hold = 0; mdir = 3; mpend = 3; mscore = 0; mhs = 0;
      end
      v   = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 6);
      case (sel)
        0: w = C_ENTER;
        1: w = C_UP;
        2: w = C_DOWN;
        3: w = C_LEFT;
        4: w = C_RIGHT;
        default: w = $urandom;
      endcase
      tk = ($urandom_range(0, 2) == 0);
      go = ($urandom_range(0, 59) == 0) && !tk;
      if ($urandom_range(0, 15) == 0) length = 8'($urandom);

      is_enter = v && (sel == 0);
      is_dir   = v && (sel >= 1) && (sel <= 4);
      code     = (sel == 1) ? 0 : (sel == 2) ? 1 : (sel == 3) ? 2 : 3;

      nphase = phase; narm = arm_left; nhold = hold; ndir = mdir; npend = mpend;
      nhs = mhs; nstep = 0;
      case (phase)
        P_START: if (is_enter) begin nphase = P_ARM; narm = ARM_N; end
        P_ARM: begin
          ndir = 3; npend = 3; narm = arm_left - 1;
          if (narm == 0) nphase = P_PLAY;
        end
        P_PLAY: begin
          if (go) begin
            nphase = P_OVER; nhold = 0;
            if (mscore > mhs) nhs = mscore;
          end else begin
            if (tk) begin nstep = 1; ndir = mpend; end
            if (is_dir && code != (mdir ^ 1)) npend = code;
            if (is_enter) nphase = P_PAUSE;
          end
        end
        P_PAUSE: if (is_enter) nphase = P_PLAY;
        P_OVER: begin
          if (is_enter && hold == HOLD_N) nphase = P_START;
          else if (tk && hold < HOLD_N) nhold = hold + 1;
        end
        default: nphase = P_START;
      endcase
      nscore = int'(length) * MULT;
      esel = (nphase == P_START) ? 0 : (nphase == P_OVER) ? 2 : (nphase == P_PAUSE) ? 3 : 1;

      ir_word = w; ir_valid = v; game_tick = tk; game_over = go;
      clk1();
      ir_valid = 1'b0; game_tick = 1'b0; game_over = 1'b0;

      phase = nphase; arm_left = narm; hold = nhold; mdir = ndir; mpend = npend;
      mscore = nscore; mhs = nhs;

      exp_v = {((phase == P_PLAY) || (phase == P_PAUSE) || (phase == P_OVER)), 1'(nstep),
               2'(mdir), 2'(esel), 11'(mscore), (HS_EN ? 11'(mhs) : 11'd0)};
      got_v = {game_rst_n, step, dir, screen_sel, score, high_score};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %b expected %b", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    ir_word   = 32'd0;
    ir_valid  = 1'b0;
    game_tick = 1'b0;
    game_over = 1'b0;
    length    = 8'd0;
    test_reset();
    test_arm();
    test_direction();
    test_last_wins();
    test_back_to_back();
    test_pause();
    test_over();
    test_second_game();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
